spi_master: RTL and testbench

//   Single-clock SPI controller that drives cs/sck/mosi and captures miso; the initiator end
//   of the link served by our SPI peripheral. Idle sck low; data changes on falling sck and is

---
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_master.sv | 140 ++++++++++++++
 tb/tb_spi_master.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Host/pin bundle for the SPI controller: start/done handshake plus the four SPI pins.
interface spi_master_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  cs;
   logic                  sck;
   logic                  mosi;
   logic                  miso;

   // Controller side
   modport master (
      input  start, tx_data, miso,
      output busy, done, rx_data, cs, sck, mosi
   );

   // Host / peripheral side
   modport slave (
      output start, tx_data, miso,
      input  busy, done, rx_data, cs, sck, mosi
   );
endinterface

// File: rtl/spi_master.sv
// SPI controller (mode 0 timing): idle sck low, mosi changes on falling sck,
// miso sampled on rising sck. One cs-low frame per accepted start.
// mosi goes out LSB first; the first miso bit lands in the rx MSB.
module spi_master #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2
) (
   input  logic          clk,
   input  logic          reset,
   spi_master_if.master  bus
);
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  cs_q, cs_d;
   logic                  sck_q, sck_d;
   logic                  mosi_q, mosi_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic                  wrap;

   // Half-period counter reaches its last count; every phase change happens here
   assign wrap = (cnt_q == CNT_LAST);

   // Next-state and next-output logic; all outputs are taken from registers
   always_comb begin
      state_d    = state_q;
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      bit_d      = bit_q;
      cs_d       = cs_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rx_data_d  = rx_data_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.start) begin
               state_d    = SETUP;
               busy_d     = 1'b1;
               cs_d       = 1'b0;
               mosi_d     = bus.tx_data[0];
               tx_shift_d = bus.tx_data;
               bit_d      = '0;
            end
         end
         SETUP: begin
            // Leaving setup is the first rising sck edge
            if (wrap) begin
               state_d    = SHIFT;
               sck_d      = 1'b1;
               rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], bus.miso};
            end
         end
         SHIFT: begin
            if (wrap) begin
               if (!sck_q) begin
                  sck_d      = 1'b1;
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], bus.miso};
               end else begin
                  sck_d = 1'b0;
                  bit_d = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     state_d = HOLD;
                  end else begin
                     tx_shift_d = tx_shift_q >> 1;
                     mosi_d     = tx_shift_q[1];
                  end
               end
            end
         end
         HOLD: begin
            if (wrap) begin
               state_d   = GAP;
               cs_d      = 1'b1;
               rx_data_d = rx_shift_q;
               done_d    = 1'b1;
            end
         end
         GAP: begin
            if (wrap) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers; reset aborts any frame immediately
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         cs_q      <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         cs_q      <= cs_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
      end
   end

   // Shift registers are fully reloaded/overwritten by every frame, so no reset
   always_ff @(posedge clk) begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
   end

   assign bus.cs      = cs_q;
   assign bus.sck     = sck_q;
   assign bus.mosi    = mosi_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=2 and CLK_DIV=1 instances, loopback,
// a small SPI peripheral model, back-to-back frames and mid-frame reset.
module tb_spi_master;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_master_if #(.DATA_WIDTH(8)) sif2 ();
   spi_master_if #(.DATA_WIDTH(8)) sif1 ();

   spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) u_dut2 (.clk(clk), .reset(reset), .bus(sif2.master));
   spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(sif1.master));

   // Peripheral model: preloaded byte goes out MSB first, changes on falling sck
   logic       miso_sel = 1'b0;
   logic [7:0] per_load = 8'h00;
   logic [7:0] per_sh   = 8'h00;
   logic [7:0] per_rx   = 8'h00;
   logic       per_armed = 1'b0;
   always @(sif2.cs or negedge sif2.sck) begin
      if (sif2.cs) per_armed = 1'b0;
      else if (!per_armed) begin per_sh = per_load; per_armed = 1'b1; end
      else per_sh = per_sh << 1;
   end
   always @(posedge sif2.sck) per_rx = {sif2.mosi, per_rx[7:1]};

   assign sif2.miso = miso_sel ? per_sh[7] : sif2.mosi;
   assign sif1.miso = 1'b0;

   // Counts mosi changes inside a frame that do not coincide with a falling sck
   int   mon_bad   = 0;
   logic mon_pcs   = 1'b1;
   logic mon_psck  = 1'b0;
   logic mon_pmosi = 1'b0;
   always @(negedge clk) begin
      if (mon_pcs == 1'b0 && sif2.cs == 1'b0 && sif2.mosi !== mon_pmosi
          && !(mon_psck == 1'b1 && sif2.sck == 1'b0))
         mon_bad++;
      mon_pcs   = sif2.cs;
      mon_psck  = sif2.sck;
      mon_pmosi = sif2.mosi;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present tx and start, let one edge accept it; returns just after the acceptance edge
   task automatic accept2(input logic [7:0] tx);
      sif2.tx_data = tx;
      sif2.start   = 1'b1;
      tick;
      sif2.start   = 1'b0;
   endtask

   initial begin
      int rises, kdone, kbusy, krise, kfall, ndone, r1, r2, bad0;
      logic psck;
      logic [7:0] seq;

      reset = 1'b1;
      sif2.start = 1'b1; sif2.tx_data = 8'h00;
      sif1.start = 1'b1; sif1.tx_data = 8'h00;

      // 1. reset with start held
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rst_cs", sif2.cs, 1'b1);
         chk("rst_sck", sif2.sck, 1'b0);
         chk("rst_busy", sif2.busy, 1'b0);
         chk("rst_done", sif2.done, 1'b0);
         chk("rst_rx", sif2.rx_data, 8'h00);
      end
      reset = 1'b0;
      tick;
      chk("post_rst_accept_cs", sif2.cs, 1'b0);
      chk("post_rst_accept_busy", sif2.busy, 1'b1);
      sif2.start = 1'b0;
      sif1.start = 1'b0;
      repeat (45) tick;

      // 2. loopback, tx=0x01, tx_data changed after acceptance
      miso_sel = 1'b0;
      accept2(8'h01);
      sif2.tx_data = 8'hFF;
      rises = 0; seq = '0; kdone = 0; kbusy = 0; psck = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) tick;
         if (sif2.sck && !psck) begin
            if (rises < 8) seq[rises] = sif2.mosi;
            rises++;
         end
         psck = sif2.sck;
         if (sif2.done && kdone == 0) kdone = k;
         if (!sif2.busy && kbusy == 0) kbusy = k;
      end
      chk("t2_rises", rises, 8);
      chk("t2_mosi_seq", seq, 8'h01);
      chk("t2_done_time", kdone, 35);
      chk("t2_busy_low_time", kbusy, 37);
      chk("t2_rx", sif2.rx_data, 8'h80);

      // 3. against the peripheral model
      miso_sel = 1'b1;
      per_load = 8'h3C;
      bad0 = mon_bad;
      accept2(8'h96);
      repeat (40) tick;
      chk("t3_rx", sif2.rx_data, 8'h3C);
      chk("t3_per_rx", per_rx, 8'h96);
      chk("t3_mosi_on_fall", mon_bad - bad0, 0);
      miso_sel = 1'b0;

      // 4. CLK_DIV=1 instance, tx=0xFF, miso=0
      sif1.tx_data = 8'hFF;
      sif1.start   = 1'b1;
      tick;
      sif1.start   = 1'b0;
      rises = 0; kdone = 0; kbusy = 0; r1 = 0; r2 = 0; psck = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         if (k > 1) tick;
         if (sif1.sck && !psck) begin
            rises++;
            if (rises == 1) r1 = k;
            if (rises == 2) r2 = k;
         end
         psck = sif1.sck;
         if (sif1.done && kdone == 0) kdone = k;
         if (!sif1.busy && kbusy == 0) kbusy = k;
      end
      chk("t4_rises", rises, 8);
      chk("t4_first_rise", r1, 2);
      chk("t4_sck_period", r2 - r1, 2);
      chk("t4_done_time", kdone, 18);
      chk("t4_busy_low_time", kbusy, 19);
      chk("t4_rx", sif1.rx_data, 8'h00);

      // 5. start pulse mid-frame ignored; start held through done gives back-to-back frame
      accept2(8'h0F);
      ndone = 0; kdone = 0; krise = 0; kfall = 0;
      for (int k = 1; k <= 80; k++) begin
         if (k > 1) tick;
         if (k == 5) sif2.start = 1'b1;
         if (k == 6) sif2.start = 1'b0;
         if (k == 30) sif2.start = 1'b1;
         if (sif2.done) begin
            ndone++;
            if (kdone == 0) kdone = k;
         end
         if (krise == 0 && k > 1 && sif2.cs) krise = k;
         else if (krise != 0 && kfall == 0 && !sif2.cs) begin
            kfall = k;
            sif2.start = 1'b0;
         end
      end
      chk("t5_done_time", kdone, 35);
      chk("t5_cs_rise_time", krise, 35);
      chk("t5_cs_gap", kfall - krise, 3);
      chk("t5_done_count", ndone, 2);
      chk("t5_rx", sif2.rx_data, 8'hF0);
      chk("t5_idle_busy", sif2.busy, 1'b0);

      // 6. reset one cycle after the 3rd sck rise
      accept2(8'hA5);
      rises = 0; psck = 1'b0;
      for (int k = 1; k <= 40 && rises < 3; k++) begin
         if (k > 1) tick;
         if (sif2.sck && !psck) rises++;
         psck = sif2.sck;
      end
      chk("t6_reached_3rd_rise", rises, 3);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("t6_cs", sif2.cs, 1'b1);
      chk("t6_sck", sif2.sck, 1'b0);
      chk("t6_busy", sif2.busy, 1'b0);
      chk("t6_mosi", sif2.mosi, 1'b0);
      chk("t6_rx", sif2.rx_data, 8'h00);
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         if (sif2.done) ndone++;
         tick;
      end
      chk("t6_no_done", ndone, 0);
      chk("t6_still_idle", sif2.cs, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
